// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-requester round-robin front end for a single-port
// 1024x8 RAM. Each requester sees its own req/gnt command port and a
// rvalid/rdata return path, giving the RAM a dual-port view.
module ram_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  // requester A
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  // requester B
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  // RAM side
  output logic              ram_wr,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_add,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR    = 2'd1,
    RD    = 2'd2,
    RWAIT = 2'd3
  } state_t;

  state_t state_r;
  logic   ptr_r;     // 0: A holds priority on a tie, 1: B holds it
  logic   owner_r;   // requester served by the operation in flight (0 = A)

  logic              pick_b_s;
  logic              any_req_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;

  // Winner selection: a lone requester always wins, a tie goes to the pointer holder.
  always_comb begin
    pick_b_s    = 1'b0;
    any_req_s   = a_req | b_req;
    sel_we_s    = a_we;
    sel_addr_s  = a_addr;
    sel_wdata_s = a_wdata;
    if (a_req && b_req) begin
      pick_b_s = ptr_r;
    end else if (b_req) begin
      pick_b_s = 1'b1;
    end else begin
      pick_b_s = 1'b0;
    end
    if (pick_b_s) begin
      sel_we_s    = b_we;
      sel_addr_s  = b_addr;
      sel_wdata_s = b_wdata;
    end else begin
      sel_we_s    = a_we;
      sel_addr_s  = a_addr;
      sel_wdata_s = a_wdata;
    end
  end

  // Control FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      ptr_r    <= 1'b0;
      owner_r  <= 1'b0;
      a_gnt    <= 1'b0;
      a_rvalid <= 1'b0;
      a_rdata  <= {DATA_W{1'b0}};
      b_gnt    <= 1'b0;
      b_rvalid <= 1'b0;
      b_rdata  <= {DATA_W{1'b0}};
      ram_wr   <= 1'b0;
      ram_rd   <= 1'b0;
      ram_add  <= {ADDR_W{1'b0}};
      ram_din  <= {DATA_W{1'b0}};
      busy     <= 1'b0;
    end else begin
      // pulses default low; they are raised for exactly one cycle below
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            owner_r <= pick_b_s;
            ptr_r   <= ~pick_b_s;   // pointer moves only on acceptance
            ram_add <= sel_addr_s;  // the address register doubles as the command latch
            a_gnt   <= ~pick_b_s;
            b_gnt   <= pick_b_s;
            busy    <= 1'b1;
            if (sel_we_s) begin
              state_r <= WR;
              ram_wr  <= 1'b1;
              ram_rd  <= 1'b0;
              ram_din <= sel_wdata_s;
            end else begin
              state_r <= RD;
              ram_wr  <= 1'b0;
              ram_rd  <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
            ram_wr  <= 1'b0;
            ram_rd  <= 1'b0;
            busy    <= 1'b0;
          end
        end
        WR: begin
          state_r <= IDLE;
          ram_wr  <= 1'b0;
          ram_rd  <= 1'b0;
          busy    <= 1'b0;
        end
        RD: begin
          // keep the read strobe and address up for the RAM's access cycle
          state_r <= RWAIT;
          ram_wr  <= 1'b0;
          ram_rd  <= 1'b1;
          busy    <= 1'b1;
        end
        RWAIT: begin
          state_r <= IDLE;
          ram_wr  <= 1'b0;
          ram_rd  <= 1'b0;
          busy    <= 1'b0;
          if (owner_r) begin
            b_rvalid <= 1'b1;
            b_rdata  <= ram_dout;
          end else begin
            a_rvalid <= 1'b1;
            a_rdata  <= ram_dout;
          end
        end
        default: begin
          state_r <= IDLE;
          ram_wr  <= 1'b0;
          ram_rd  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
